data_ram_arbiter: RTL and testbench

DATA_RAM_ARBITER -- requirements
Module: data_ram_arbiter

---
 rtl/data_ram_arbiter.sv | 135 +++++++++++++
 tb/tb_data_ram_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_arbiter.sv
// Two-port (core A / DMA B) arbiter onto a single-port data RAM with in-order load returns.
// Define DATA_RAM_ARB_RR_EN for round-robin on conflict; otherwise A has fixed priority.
module data_ram_arbiter #(
    parameter int unsigned READ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [2:0]  a_op,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [2:0]  b_op,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        a_gnt,
    output logic        b_gnt,
    output logic        a_rvalid,
    output logic        b_rvalid,
    output logic [31:0] a_rdata,
    output logic [31:0] b_rdata,
    output logic        ram_wen_n,
    output logic [2:0]  ram_op,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout
);

    localparam logic [2:0] IdleOp = 3'b010;

    logic pick_b;

`ifdef DATA_RAM_ARB_RR_EN
    logic prio_q, prio_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

    // Point at the loser after every grant; hold when idle.
    always_comb begin
        prio_d = prio_q;
        if (a_gnt) begin
            prio_d = 1'b1;
        end else if (b_gnt) begin
            prio_d = 1'b0;
        end
    end

    assign pick_b = prio_q;
`else
    assign pick_b = 1'b0;
`endif

    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!rst) begin
            if (a_req && b_req) begin
                a_gnt = !pick_b;
                b_gnt = pick_b;
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
        end
    end

    always_comb begin
        ram_wen_n = 1'b1;
        ram_op    = IdleOp;
        ram_addr  = '0;
        ram_din   = '0;
        unique case ({a_gnt, b_gnt})
            2'b10: begin
                ram_wen_n = ~a_we;
                ram_op    = a_op;
                ram_addr  = a_addr;
                ram_din   = a_wdata;
            end
            2'b01: begin
                ram_wen_n = ~b_we;
                ram_op    = b_op;
                ram_addr  = b_addr;
                ram_din   = b_wdata;
            end
            default: begin
                ram_wen_n = 1'b1;
            end
        endcase
    end

    // Tag pipeline tracks which side owns the RAM data emerging READ_LAT cycles later.
    logic [READ_LAT-1:0] tag_valid_q;
    logic [READ_LAT-1:0] tag_owner_q;
    logic                push_valid;
    logic                push_owner;

    assign push_valid = (a_gnt && !a_we) || (b_gnt && !b_we);
    assign push_owner = b_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid_q <= '0;
            tag_owner_q <= '0;
        end else begin
            tag_valid_q[0] <= push_valid;
            tag_owner_q[0] <= push_owner;
            for (int i = 1; i < READ_LAT; i++) begin
                tag_valid_q[i] <= tag_valid_q[i-1];
                tag_owner_q[i] <= tag_owner_q[i-1];
            end
        end
    end

    logic resp_valid;
    logic resp_owner;

    assign resp_valid = tag_valid_q[READ_LAT-1] && !rst;
    assign resp_owner = tag_owner_q[READ_LAT-1];

    always_comb begin
        a_rvalid = resp_valid && !resp_owner;
        b_rvalid = resp_valid && resp_owner;
        a_rdata  = a_rvalid ? ram_dout : '0;
        b_rdata  = b_rvalid ? ram_dout : '0;
    end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Randomized bench for data_ram_arbiter: READ_LAT=1 and READ_LAT=2 instances share stimulus
// and are checked every cycle against a queue-based behavioural model.
module tb_data_ram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [2:0]  a_op, b_op;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;

    logic        a_gnt1, b_gnt1, a_rvalid1, b_rvalid1, ram_wen_n1;
    logic [31:0] a_rdata1, b_rdata1, ram_addr1, ram_din1, ram_dout1;
    logic [2:0]  ram_op1;
    logic        a_gnt2, b_gnt2, a_rvalid2, b_rvalid2, ram_wen_n2;
    logic [31:0] a_rdata2, b_rdata2, ram_addr2, ram_din2, ram_dout2;
    logic [2:0]  ram_op2;

    data_ram_arbiter #(.READ_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_op(a_op), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_op(b_op), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt1), .b_gnt(b_gnt1), .a_rvalid(a_rvalid1), .b_rvalid(b_rvalid1),
        .a_rdata(a_rdata1), .b_rdata(b_rdata1),
        .ram_wen_n(ram_wen_n1), .ram_op(ram_op1), .ram_addr(ram_addr1), .ram_din(ram_din1),
        .ram_dout(ram_dout1)
    );

    data_ram_arbiter #(.READ_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_op(a_op), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_op(b_op), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt2), .b_gnt(b_gnt2), .a_rvalid(a_rvalid2), .b_rvalid(b_rvalid2),
        .a_rdata(a_rdata2), .b_rdata(b_rdata2),
        .ram_wen_n(ram_wen_n2), .ram_op(ram_op2), .ram_addr(ram_addr2), .ram_din(ram_din2),
        .ram_dout(ram_dout2)
    );

    function automatic logic [31:0] init_word(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {8'hA5, b, ~b, b};
    endfunction

    // RAM fixtures: unwritten words read as init_word().
    logic [31:0] mem1 [256];
    logic [31:0] mem2 [256];
    logic [255:0] wr1 = '0, wr2 = '0;
    logic [31:0] r1, r2a, r2b;

    always @(posedge clk) begin
        if (!ram_wen_n1) begin
            mem1[ram_addr1[7:0]] <= ram_din1;
            wr1[ram_addr1[7:0]]  <= 1'b1;
        end
        r1 <= wr1[ram_addr1[7:0]] ? mem1[ram_addr1[7:0]] : init_word(int'(ram_addr1[7:0]));
    end

    always @(posedge clk) begin
        if (!ram_wen_n2) begin
            mem2[ram_addr2[7:0]] <= ram_din2;
            wr2[ram_addr2[7:0]]  <= 1'b1;
        end
        r2a <= wr2[ram_addr2[7:0]] ? mem2[ram_addr2[7:0]] : init_word(int'(ram_addr2[7:0]));
        r2b <= r2a;
    end

    assign ram_dout1 = r1;
    assign ram_dout2 = r2b;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model
    typedef struct {
        logic        owner;
        logic [31:0] data;
        int          due;
    } resp_t;

    resp_t       q1[$];
    resp_t       q2[$];
    logic [31:0] mm [256];
    logic        prio_m;

    initial begin
        int cyc;
        logic ega, egb, e_wen;
        logic [2:0] e_op;
        logic [31:0] e_addr, e_din;
        logic e1v, e1o, e2v, e2o;
        logic [31:0] e1d, e2d;
        resp_t r;
        cyc = 0;
        prio_m = 1'b0;
        for (int i = 0; i < 256; i++) mm[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (rst) begin
                prio_m = 1'b0;
                q1.delete();
                q2.delete();
            end
            ega = 1'b0;
            egb = 1'b0;
            if (!rst) begin
                if (a_req && b_req) begin
`ifdef DATA_RAM_ARB_RR_EN
                    ega = !prio_m;
                    egb = prio_m;
`else
                    ega = 1'b1;
`endif
                end else begin
                    ega = a_req;
                    egb = b_req;
                end
            end
            e_wen = 1'b1; e_op = 3'b010; e_addr = 0; e_din = 0;
            if (ega) begin
                e_wen = !a_we; e_op = a_op; e_addr = a_addr; e_din = a_wdata;
            end else if (egb) begin
                e_wen = !b_we; e_op = b_op; e_addr = b_addr; e_din = b_wdata;
            end
            chk("a_gnt1", a_gnt1, ega);       chk("b_gnt1", b_gnt1, egb);
            chk("a_gnt2", a_gnt2, ega);       chk("b_gnt2", b_gnt2, egb);
            chk("wen_n1", ram_wen_n1, e_wen); chk("op1", ram_op1, e_op);
            chk("addr1", ram_addr1, e_addr);  chk("din1", ram_din1, e_din);
            chk("wen_n2", ram_wen_n2, e_wen); chk("op2", ram_op2, e_op);
            chk("addr2", ram_addr2, e_addr);  chk("din2", ram_din2, e_din);

            e1v = 0; e1o = 0; e1d = 0; e2v = 0; e2o = 0; e2d = 0;
            if (q1.size() > 0 && q1[0].due == cyc) begin
                r = q1.pop_front(); e1v = 1; e1o = r.owner; e1d = r.data;
            end
            if (q2.size() > 0 && q2[0].due == cyc) begin
                r = q2.pop_front(); e2v = 1; e2o = r.owner; e2d = r.data;
            end
            chk("a_rvalid1", a_rvalid1, e1v && !e1o); chk("b_rvalid1", b_rvalid1, e1v && e1o);
            chk("a_rdata1", a_rdata1, (e1v && !e1o) ? e1d : 0);
            chk("b_rdata1", b_rdata1, (e1v && e1o) ? e1d : 0);
            chk("a_rvalid2", a_rvalid2, e2v && !e2o); chk("b_rvalid2", b_rvalid2, e2v && e2o);
            chk("a_rdata2", a_rdata2, (e2v && !e2o) ? e2d : 0);
            chk("b_rdata2", b_rdata2, (e2v && e2o) ? e2d : 0);

            if (ega || egb) begin
                if (e_wen) begin
                    q1.push_back('{owner: egb, data: mm[e_addr[7:0]], due: cyc + 1});
                    q2.push_back('{owner: egb, data: mm[e_addr[7:0]], due: cyc + 2});
                end else begin
                    mm[e_addr[7:0]] = e_din;
                end
                prio_m = ega;
            end
            cyc++;
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
        a_req = req; a_we = we; a_op = 3'b010; a_addr = addr; a_wdata = wdata;
    endtask

    task automatic set_b(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
        b_req = req; b_we = we; b_op = 3'b010; b_addr = addr; b_wdata = wdata;
    endtask

    initial begin
        logic [5:0] ga, gb;
        int ca, cb;
        logic pa, pb;
        rst = 1'b1;
        set_a(1, 0, 32'h4, 0);
        set_b(1, 0, 32'h8, 0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_a_gnt", a_gnt1, 0);   chk("rst_b_gnt", b_gnt1, 0);
            chk("rst_wen_n", ram_wen_n1, 1); chk("rst_op", ram_op1, 3'b010);
            chk("rst_addr", ram_addr1, 0); chk("rst_a_rvalid", a_rvalid1, 0);
        end

        // Lone A load of 0x10.
        nxt(); rst = 1'b0;
        set_a(1, 0, 32'h10, 0); set_b(0, 0, 0, 0);
        @(negedge clk);
        chk("l10_a_gnt", a_gnt1, 1); chk("l10_wen_n", ram_wen_n1, 1);
        chk("l10_addr", ram_addr1, 32'h10);
        nxt(); set_a(0, 0, 0, 0);
        @(negedge clk);
        chk("l10_a_rvalid", a_rvalid1, 1); chk("l10_a_rdata", a_rdata1, 32'hA510EF10);
        chk("l10_b_rvalid", b_rvalid1, 0);

        // Both load continuously from a fresh reset.
        nxt(); rst = 1'b1;
        nxt(); rst = 1'b0;
        set_a(1, 0, 32'h1, 0); set_b(1, 0, 32'h2, 0);
        ca = 0; cb = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            ga[k] = a_gnt1; gb[k] = b_gnt1;
            ca += int'(a_rvalid1); cb += int'(b_rvalid1);
            nxt();
        end
        set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
        repeat (2) begin
            @(negedge clk);
            ca += int'(a_rvalid1); cb += int'(b_rvalid1);
            nxt();
        end
`ifdef DATA_RAM_ARB_RR_EN
        chk("both_a_gnts", 32'(ga), 32'h15); chk("both_b_gnts", 32'(gb), 32'h2A);
        chk("both_a_resp", ca, 3);           chk("both_b_resp", cb, 3);
`else
        chk("both_a_gnts", 32'(ga), 32'h3F); chk("both_b_gnts", 32'(gb), 32'h00);
        chk("both_a_resp", ca, 6);           chk("both_b_resp", cb, 0);
`endif

        // B store then A load of the same word.
        set_b(1, 1, 32'h20, 32'hDEADBEEF);
        @(negedge clk);
        chk("st_b_gnt", b_gnt1, 1); chk("st_wen_n", ram_wen_n1, 0);
        chk("st_din", ram_din1, 32'hDEADBEEF);
        nxt(); set_b(0, 0, 0, 0); set_a(1, 0, 32'h20, 0);
        @(negedge clk);
        chk("ld_a_gnt", a_gnt1, 1); chk("ld_wen_n", ram_wen_n1, 1);
        nxt(); set_a(0, 0, 0, 0);
        @(negedge clk);
        chk("ld_a_rvalid1", a_rvalid1, 1); chk("ld_a_rdata1", a_rdata1, 32'hDEADBEEF);
        nxt();
        @(negedge clk);
        chk("ld_a_rvalid2", a_rvalid2, 1); chk("ld_a_rdata2", a_rdata2, 32'hDEADBEEF);

        // READ_LAT=2 load killed by a reset the following cycle.
        nxt(); set_a(1, 0, 32'h30, 0);
        @(negedge clk);
        chk("kill_a_gnt", a_gnt2, 1);
        nxt(); rst = 1'b1; set_a(1, 0, 32'h31, 0); set_b(1, 0, 32'h32, 0);
        @(negedge clk);
        chk("kill_rst_a_gnt", a_gnt2, 0);    chk("kill_rst_b_gnt", b_gnt2, 0);
        chk("kill_rst_wen_n", ram_wen_n2, 1); chk("kill_rst_op", ram_op2, 3'b010);
        chk("kill_rst_addr", ram_addr2, 0);  chk("kill_rst_din", ram_din2, 0);
        chk("kill_rst_rvalid", a_rvalid2, 0); chk("kill_rst_rdata", a_rdata2, 0);
        nxt(); rst = 1'b0;
        @(negedge clk);
        chk("kill_no_rvalid", a_rvalid2, 0);
        chk("kill_prio_a", a_gnt2, 1); chk("kill_prio_b", b_gnt2, 0);

        // Idle.
        nxt(); set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
        nxt(); nxt(); nxt();
        repeat (5) begin
            @(negedge clk);
            chk("idle_wen_n", ram_wen_n1, 1); chk("idle_op", ram_op1, 3'b010);
            chk("idle_addr", ram_addr1, 0);   chk("idle_gnt", a_gnt1 | b_gnt1, 0);
            chk("idle_rvalid", a_rvalid1 | b_rvalid1 | a_rvalid2 | b_rvalid2, 0);
            nxt();
        end

        // Random traffic; pending requests held until granted, occasionally abandoned.
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            pa = a_gnt1; pb = b_gnt1;
            nxt();
            rst = ($urandom % 64) == 0;
            if (!(a_req && !pa && ($urandom % 16) != 0)) begin
                a_req = ($urandom % 4) != 0; a_we = ($urandom % 3) == 0;
                a_op = 3'($urandom); a_addr = $urandom % 32; a_wdata = $urandom;
            end
            if (!(b_req && !pb && ($urandom % 16) != 0)) begin
                b_req = ($urandom % 4) != 0; b_we = ($urandom % 3) == 0;
                b_op = 3'($urandom); b_addr = $urandom % 32; b_wdata = $urandom;
            end
        end
        rst = 1'b0; set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
        repeat (4) nxt();
        @(negedge clk);
        chk("drain_q1", q1.size(), 0); chk("drain_q2", q2.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
